// File: rtl/uart_host_ctrl.sv
// Host-side command sequencer for a byte UART: frames load/read/start commands,
// streams source memory out over tx and writes received bytes into sink memory.
module uart_host_ctrl #(
  parameter int ADDR_WIDTH   = 19,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [23:0]           cmd_len,
  output logic [7:0]            tx_data,
  output logic                  tx_wr_en,
  input  logic                  tx_busy,
  input  logic [7:0]            rx_data,
  input  logic                  rx_rdy,
  output logic                  rx_rdy_clr,
  output logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [7:0]            src_data,
  output logic                  snk_we,
  output logic [ADDR_WIDTH-1:0] snk_addr,
  output logic [7:0]            snk_data,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE, SEND_OP, SEND_LEN, SEND_DATA, RECV_DATA, WAIT_END, FINISH
  } state_t;

  localparam int GW = $clog2(GUARD_CYCLES + 2);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES);

  state_t          state_reg;
  logic [2:0]      op_reg;
  logic [23:0]     len_reg;
  logic [23:0]     cnt_reg;
  logic [1:0]      len_idx_reg;
  logic [1:0]      fetch_reg;
  logic [GW-1:0]   guard_reg;

  logic        tx_ok;
  logic        rx_new;
  logic        accept;
  logic [23:0] cnt_inc;

  // A byte may go out only once the guard window has elapsed and the UART is idle.
  assign tx_ok   = (guard_reg == '0) && !tx_busy && !tx_wr_en;
  assign rx_new  = rx_rdy && !rx_rdy_clr;
  assign accept  = cmd_valid && cmd_ready;
  assign cnt_inc = cnt_reg + 24'd1;

  function automatic logic [7:0] op_byte(input logic [2:0] op);
    case (op)
      3'd0:    op_byte = 8'hFF;
      3'd1:    op_byte = 8'hFD;
      3'd2:    op_byte = 8'hFE;
      3'd3:    op_byte = 8'hFC;
      3'd4:    op_byte = 8'hF9;
      3'd5:    op_byte = 8'hF0;
      default: op_byte = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      op_reg      <= '0;
      len_reg     <= '0;
      cnt_reg     <= '0;
      len_idx_reg <= '0;
      fetch_reg   <= '0;
      guard_reg   <= '0;
      cmd_ready   <= 1'b0;
      tx_data     <= '0;
      tx_wr_en    <= 1'b0;
      rx_rdy_clr  <= 1'b0;
      src_addr    <= '0;
      snk_we      <= 1'b0;
      snk_addr    <= '0;
      snk_data    <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      tx_wr_en   <= 1'b0;
      rx_rdy_clr <= 1'b0;
      snk_we     <= 1'b0;
      done       <= 1'b0;
      if (guard_reg != '0) guard_reg <= guard_reg - GW'(1);

      case (state_reg)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            op_reg      <= cmd_op;
            len_reg     <= cmd_len;
            cnt_reg     <= '0;
            len_idx_reg <= '0;
            fetch_reg   <= '0;
            err         <= 1'b0;
            cmd_ready   <= 1'b0;
            state_reg   <= SEND_OP;
          end else if (rx_new) begin
            rx_rdy_clr <= 1'b1;
            err        <= 1'b1;
          end
        end

        SEND_OP: begin
          if (op_reg > 3'd5) begin
            err       <= 1'b1;
            state_reg <= FINISH;
          end else if (tx_ok) begin
            tx_data   <= op_byte(op_reg);
            tx_wr_en  <= 1'b1;
            guard_reg <= GUARD_LOAD;
            case (op_reg)
              3'd0, 3'd1:       state_reg <= SEND_LEN;
              3'd2, 3'd3, 3'd4: state_reg <= RECV_DATA;
              default:          state_reg <= WAIT_END;
            endcase
          end
        end

        SEND_LEN: begin
          if (tx_ok) begin
            case (len_idx_reg)
              2'd0:    tx_data <= len_reg[23:16];
              2'd1:    tx_data <= len_reg[15:8];
              default: tx_data <= len_reg[7:0];
            endcase
            tx_wr_en    <= 1'b1;
            guard_reg   <= GUARD_LOAD;
            len_idx_reg <= len_idx_reg + 2'd1;
            if (len_idx_reg == 2'd2)
              state_reg <= (len_reg == '0) ? FINISH : SEND_DATA;
          end
        end

        // Address phase, one settle cycle for the registered memory read, then send.
        SEND_DATA: begin
          case (fetch_reg)
            2'd0: begin
              if (cnt_reg == len_reg) begin
                state_reg <= FINISH;
              end else begin
                src_addr  <= ADDR_WIDTH'(cnt_reg);
                fetch_reg <= 2'd1;
              end
            end
            2'd1: fetch_reg <= 2'd2;
            default: begin
              if (tx_ok) begin
                tx_data   <= src_data;
                tx_wr_en  <= 1'b1;
                guard_reg <= GUARD_LOAD;
                cnt_reg   <= cnt_inc;
                fetch_reg <= 2'd0;
              end
            end
          endcase
        end

        RECV_DATA: begin
          if (cnt_reg == len_reg) begin
            state_reg <= FINISH;
          end else if (rx_new) begin
            rx_rdy_clr <= 1'b1;
            snk_we     <= 1'b1;
            snk_addr   <= ADDR_WIDTH'(cnt_reg);
            snk_data   <= rx_data;
            cnt_reg    <= cnt_inc;
          end
        end

        WAIT_END: begin
          if (rx_new) begin
            rx_rdy_clr <= 1'b1;
            if (rx_data == 8'hEF) state_reg <= FINISH;
            else                  err       <= 1'b1;
          end
        end

        FINISH: begin
          done      <= 1'b1;
          cmd_ready <= 1'b1;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_host_ctrl.sv
// Directed bench for uart_host_ctrl: UART/memory models, a queue-based expectation
// model, and one compare process watching every strobe the DUT emits.
module tb_uart_host_ctrl;

  localparam int AW       = 19;
  localparam int GUARD    = 2;
  localparam int BUSY_CYC = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [23:0]   cmd_len = '0;
  logic [7:0]    tx_data;
  logic          tx_wr_en;
  logic          tx_busy;
  logic [7:0]    rx_data = '0;
  logic          rx_rdy = 1'b0;
  logic          rx_rdy_clr;
  logic [AW-1:0] src_addr;
  logic [7:0]    src_data = '0;
  logic          snk_we;
  logic [AW-1:0] snk_addr;
  logic [7:0]    snk_data;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  uart_host_ctrl #(.ADDR_WIDTH(AW), .GUARD_CYCLES(GUARD)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .tx_data(tx_data), .tx_wr_en(tx_wr_en), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_rdy_clr(rx_rdy_clr),
    .src_addr(src_addr), .src_data(src_data),
    .snk_we(snk_we), .snk_addr(snk_addr), .snk_data(snk_data),
    .done(done), .err(err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- environment models ----------------
  logic [7:0] src_mem [256];
  always @(posedge clk) src_data <= src_mem[src_addr[7:0]];

  int busy_left = 0;
  always @(posedge clk) begin
    if (tx_wr_en)            busy_left <= BUSY_CYC;
    else if (busy_left != 0) busy_left <= busy_left - 1;
  end
  assign tx_busy = (busy_left != 0);

  int rx_q[$];
  int ack_cnt = 0;
  always @(posedge clk) begin
    if (rx_rdy && rx_rdy_clr) begin
      rx_rdy  <= 1'b0;
      ack_cnt <= ack_cnt + 1;
    end else if (!rx_rdy && rx_q.size() != 0) begin
      rx_data <= 8'(rx_q.pop_front());
      rx_rdy  <= 1'b1;
    end
  end

  // ---------------- expectation model ----------------
  int op_code [6] = '{8'hFF, 8'hFD, 8'hFE, 8'hFC, 8'hF9, 8'hF0};
  int exp_tx[$];
  int exp_sa[$];
  int exp_sd[$];
  int rx_plan[$];
  int done_pending = 0;

  function automatic void plan(input int op, input int len);
    done_pending++;
    if (op > 5) return;
    exp_tx.push_back(op_code[op]);
    if (op <= 1) begin
      for (int s = 16; s >= 0; s -= 8) exp_tx.push_back((len >> s) & 255);
      for (int i = 0; i < len; i++) exp_tx.push_back(int'(src_mem[i & 255]));
    end else if (op <= 4) begin
      for (int i = 0; i < len; i++) begin
        exp_sa.push_back(i % (1 << AW));
        exp_sd.push_back(rx_plan[i]);
      end
    end
  endfunction

  // ---------------- compare process ----------------
  int   tx_seen  = 0;
  int   done_cnt = 0;
  int   since_wr = 100;
  logic prev_busy = 1'b0;
  logic prev_clr  = 1'b0;
  logic prev_we   = 1'b0;
  int   sink_mem [16];

  always @(negedge clk) begin
    if (tx_wr_en) begin
      tx_seen++;
      chk("tx_while_busy", int'(prev_busy), 0);
      chk("tx_guard_gap", int'(since_wr >= GUARD), 1);
      chk("tx_expected", int'(exp_tx.size() > 0), 1);
      if (exp_tx.size() > 0) chk("tx_byte", int'(tx_data), exp_tx.pop_front());
      since_wr = 0;
    end else begin
      since_wr++;
    end
    if (rx_rdy_clr) begin
      chk("rx_clr_single", int'(prev_clr), 0);
      chk("rx_clr_has_byte", int'(rx_rdy), 1);
    end
    if (snk_we) begin
      chk("snk_we_single", int'(prev_we), 0);
      chk("snk_expected", int'(exp_sa.size() > 0), 1);
      if (exp_sa.size() > 0) begin
        chk("snk_addr", int'(snk_addr), exp_sa.pop_front());
        chk("snk_data", int'(snk_data), exp_sd.pop_front());
      end
      sink_mem[snk_addr[3:0]] = int'(snk_data);
    end
    if (done) begin
      done_cnt++;
      chk("done_expected", int'(done_pending > 0), 1);
      if (done_pending > 0) done_pending--;
      chk("done_tx_drained", exp_tx.size(), 0);
      chk("done_snk_drained", exp_sa.size(), 0);
    end
    prev_busy = tx_busy;
    prev_clr  = rx_rdy_clr;
    prev_we   = snk_we;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input int op, input int len);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("cmd_ready_before_issue", int'(cmd_ready), 1);
    cmd_op    = 3'(op);
    cmd_len   = 24'(len);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("cmd_ready_drop", int'(cmd_ready), 0);
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin tick(); n++; end
    chk(name, done_cnt - d0, 1);
    tick();
    chk("cmd_ready_after_done", int'(cmd_ready), 1);
  endtask

  task automatic wait_acks(input string name, input int target);
    int n;
    n = 0;
    while (ack_cnt < target && n < 200) begin tick(); n++; end
    chk(name, ack_cnt, target);
  endtask

  int lit_load3 [7] = '{8'hFD, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
  int lit_load0 [4] = '{8'hFF, 8'h00, 8'h00, 8'h00};

  initial begin
    int a0;
    int d0;
    int t0;
    int n;
    for (int i = 0; i < 256; i++) src_mem[i] = 8'(i ^ 8'hA5);
    for (int i = 0; i < 16; i++) sink_mem[i] = 0;

    // reset state
    repeat (3) tick();
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_tx_wr_en", int'(tx_wr_en), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_src_addr", int'(src_addr), 0);
    chk("rst_snk", int'({snk_we, snk_addr, snk_data}), 0);
    rst = 1'b1;
    tick();
    chk("cmd_ready_after_rst", int'(cmd_ready), 1);

    // LOAD_IMG, 3 bytes
    src_mem[0] = 8'h11; src_mem[1] = 8'h22; src_mem[2] = 8'h33;
    plan(1, 3);
    chk("pin_load3_len", exp_tx.size(), 7);
    for (int i = 0; i < 7; i++) chk("pin_load3_byte", exp_tx[i], lit_load3[i]);
    issue(1, 3);
    wait_done("load_img3_done", 600);
    chk("load_img3_err", int'(err), 0);

    // READ_INS, 0xEF is plain data here
    rx_plan = '{8'hEF, 8'h5A};
    a0 = ack_cnt;
    plan(2, 2);
    issue(2, 2);
    rx_q.push_back(8'hEF);
    rx_q.push_back(8'h5A);
    wait_done("read_ins_done", 400);
    chk("read_ins_acks", ack_cnt - a0, 2);
    chk("read_ins_sink0", sink_mem[0], 8'hEF);
    chk("read_ins_sink1", sink_mem[1], 8'h5A);
    chk("read_ins_err", int'(err), 0);

    // LOAD_INS with zero length: header only
    plan(0, 0);
    chk("pin_load0_len", exp_tx.size(), 4);
    for (int i = 0; i < 4; i++) chk("pin_load0_byte", exp_tx[i], lit_load0[i]);
    issue(0, 0);
    wait_done("load_ins0_done", 400);
    chk("load_ins0_src_addr", int'(src_addr), 2);

    // READ_IMG with zero length
    plan(3, 0);
    issue(3, 0);
    wait_done("read_img0_done", 400);
    chk("read_img0_err", int'(err), 0);

    // stray rx byte while idle
    a0 = ack_cnt;
    rx_q.push_back(8'h42);
    wait_acks("idle_rx_ack", a0 + 1);
    tick();
    chk("idle_rx_err", int'(err), 1);

    // reserved opcode
    t0 = tx_seen;
    plan(7, 0);
    issue(7, 5);
    chk("reserved_err_cleared", int'(err), 0);
    wait_done("reserved_done", 100);
    chk("reserved_err", int'(err), 1);
    chk("reserved_no_tx", tx_seen - t0, 0);

    // START: non-terminator flags err, 0xEF completes
    plan(5, 0);
    issue(5, 0);
    chk("start_err_cleared", int'(err), 0);
    n = 0;
    while (exp_tx.size() != 0 && n < 200) begin tick(); n++; end
    chk("start_op_sent", exp_tx.size(), 0);
    a0 = ack_cnt;
    d0 = done_cnt;
    rx_q.push_back(8'h00);
    wait_acks("start_ack0", a0 + 1);
    tick(); tick();
    chk("start_err_after_00", int'(err), 1);
    chk("start_no_early_done", done_cnt - d0, 0);
    rx_q.push_back(8'hEF);
    wait_done("start_done", 200);
    chk("start_err_sticky", int'(err), 1);

    // reset during the 2nd data byte of LOAD_IMG
    src_mem[0] = 8'h11; src_mem[1] = 8'h22; src_mem[2] = 8'h33; src_mem[3] = 8'h44;
    t0 = tx_seen;
    plan(1, 4);
    issue(1, 4);
    n = 0;
    while (tx_seen < t0 + 6 && n < 600) begin tick(); n++; end
    chk("abort_reached_byte6", tx_seen - t0, 6);
    rst = 1'b0;
    exp_tx.delete();
    done_pending = 0;
    d0 = done_cnt;
    tick();
    chk("abort_rst_cmd_ready", int'(cmd_ready), 0);
    chk("abort_rst_err", int'(err), 0);
    chk("abort_rst_src_addr", int'(src_addr), 0);
    chk("abort_rst_tx_data", int'(tx_data), 0);
    rst = 1'b1;
    tick();
    chk("abort_cmd_ready_next", int'(cmd_ready), 1);
    repeat (40) tick();
    chk("abort_no_done", done_cnt - d0, 0);

    // normal command after the abort
    rx_plan = '{8'h01, 8'hEF, 8'h7E};
    a0 = ack_cnt;
    plan(4, 3);
    issue(4, 3);
    rx_q.push_back(8'h01);
    rx_q.push_back(8'hEF);
    rx_q.push_back(8'h7E);
    wait_done("read_out_done", 400);
    chk("read_out_acks", ack_cnt - a0, 3);
    chk("read_out_sink2", sink_mem[2], 8'h7E);
    chk("read_out_err", int'(err), 0);

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
